// File: rtl/tile_layer.sv
// Tile-map background layer: maps a screen pixel through a tile-map RAM into a tile ROM address.
// Define TILE_LAYER_SCROLL_EN to add i_scroll_x/i_scroll_y to the requested coordinate.
module tile_layer #(
  parameter int unsigned TILE_BITS     = 2,
  parameter int unsigned MAP_COLS_BITS = 7,
  parameter int unsigned MAP_ROWS_BITS = 7,
  parameter int unsigned TILE_ID_W     = 6,
  parameter int unsigned COLOR_W       = 24,
  parameter int unsigned COORD_W       = 9
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_pix_valid,
  input  logic [COORD_W-1:0]                   i_x,
  input  logic [COORD_W-1:0]                   i_y,
  input  logic [COORD_W-1:0]                   i_scroll_x,
  input  logic [COORD_W-1:0]                   i_scroll_y,
  input  logic                                 i_map_we,
  input  logic [MAP_COLS_BITS+MAP_ROWS_BITS-1:0] i_map_waddr,
  input  logic [TILE_ID_W-1:0]                 i_map_wdata,
  output logic [TILE_ID_W+2*TILE_BITS-1:0]     o_rom_address,
  input  logic [COLOR_W-1:0]                   i_rom_data,
  output logic [COLOR_W-1:0]                   o_color,
  output logic                                 o_color_valid,
  output logic                                 o_busy,
  output logic [7:0]                           o_drop_count
);

  localparam int unsigned PxW   = MAP_COLS_BITS + TILE_BITS;
  localparam int unsigned PyW   = MAP_ROWS_BITS + TILE_BITS;
  localparam int unsigned MapAw = MAP_COLS_BITS + MAP_ROWS_BITS;
  localparam int unsigned RomAw = TILE_ID_W + 2 * TILE_BITS;

  typedef enum logic [2:0] {StIdle, StMapRd, StCalc, StRomWait, StOut} state_e;

  state_e               state_q, state_d;
  logic [PxW-1:0]       px_q, px_d, eff_x;
  logic [PyW-1:0]       py_q, py_d, eff_y;
  logic [RomAw-1:0]     rom_addr_q, rom_addr_d, calc_addr;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic                 color_valid_q, color_valid_d;
  logic [7:0]           drop_q, drop_d;
  logic [TILE_ID_W-1:0] tile_q;
  logic [MapAw-1:0]     map_raddr;
  logic [TILE_ID_W-1:0] map_mem [2**MapAw];

`ifdef TILE_LAYER_SCROLL_EN
  assign eff_x = PxW'(i_x) + PxW'(i_scroll_x);
  assign eff_y = PyW'(i_y) + PyW'(i_scroll_y);
`else
  logic unused_scroll;
  assign unused_scroll = ^{i_scroll_x, i_scroll_y};
  assign eff_x = PxW'(i_x);
  assign eff_y = PyW'(i_y);
`endif

  assign map_raddr = {py_q[PyW-1:TILE_BITS], px_q[PxW-1:TILE_BITS]};
  assign calc_addr = {tile_q, py_q[TILE_BITS-1:0], px_q[TILE_BITS-1:0]};

  // No reset on the map: contents survive i_rst and writes are honoured during it.
  // Read and write in one block so a same-address collision returns the old word.
  always_ff @(posedge i_clk) begin
    if (i_map_we) begin
      map_mem[i_map_waddr] <= i_map_wdata;
    end
    if (state_q == StMapRd) begin
      tile_q <= map_mem[map_raddr];
    end
  end

  always_comb begin
    state_d       = state_q;
    px_d          = px_q;
    py_d          = py_q;
    rom_addr_d    = rom_addr_q;
    color_d       = color_q;
    color_valid_d = 1'b0;
    drop_d        = drop_q;

    if (i_pix_valid && (state_q != StIdle) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      StIdle: begin
        if (i_pix_valid) begin
          px_d    = eff_x;
          py_d    = eff_y;
          state_d = StMapRd;
        end
      end
      StMapRd: state_d = StCalc;
      StCalc: begin
        rom_addr_d = calc_addr;
        state_d    = StRomWait;
      end
      // ROM data is already valid here; registering it now presents colour and
      // valid during the OUT cycle, four cycles after the strobe.
      StRomWait: begin
        color_d       = i_rom_data;
        color_valid_d = 1'b1;
        state_d       = StOut;
      end
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= StIdle;
      px_q          <= '0;
      py_q          <= '0;
      rom_addr_q    <= '0;
      color_q       <= '0;
      color_valid_q <= 1'b0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      px_q          <= px_d;
      py_q          <= py_d;
      rom_addr_q    <= rom_addr_d;
      color_q       <= color_d;
      color_valid_q <= color_valid_d;
      drop_q        <= drop_d;
    end
  end

  // The address is live in CALC and then held until the next CALC.
  assign o_rom_address = (state_q == StCalc) ? calc_addr : rom_addr_q;
  assign o_color       = color_q;
  assign o_color_valid = color_valid_q;
  assign o_busy        = (state_q != StIdle);
  assign o_drop_count  = drop_q;

endmodule

// File: tb/tb_tile_layer.sv
// Directed bench for tile_layer: table of fetches plus sequences for drop, reset and collision.
module tb_tile_layer;

  logic        clk;
  logic        i_rst;
  logic        i_pix_valid;
  logic [8:0]  i_x, i_y, i_scroll_x, i_scroll_y;
  logic        i_map_we;
  logic [13:0] i_map_waddr;
  logic [5:0]  i_map_wdata;
  logic [9:0]  o_rom_address;
  logic [23:0] rom_data;
  logic [23:0] o_color;
  logic        o_color_valid;
  logic        o_busy;
  logic [7:0]  o_drop_count;

  int checks   = 0;
  int failures = 0;

  tile_layer dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_pix_valid  (i_pix_valid),
    .i_x          (i_x),
    .i_y          (i_y),
    .i_scroll_x   (i_scroll_x),
    .i_scroll_y   (i_scroll_y),
    .i_map_we     (i_map_we),
    .i_map_waddr  (i_map_waddr),
    .i_map_wdata  (i_map_wdata),
    .o_rom_address(o_rom_address),
    .i_rom_data   (rom_data),
    .o_color      (o_color),
    .o_color_valid(o_color_valid),
    .o_busy       (o_busy),
    .o_drop_count (o_drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] rom_f(input logic [9:0] a);
    return 24'(a) * 24'd40503 + 24'h001357;
  endfunction

  // Synchronous tile ROM with one cycle of read latency.
  always @(posedge clk) rom_data <= rom_f(o_rom_address);

  typedef struct {
    logic [8:0] x;
    logic [8:0] y;
    logic [9:0] addr;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic map_write(input logic [13:0] a, input logic [5:0] d);
    i_map_we    = 1'b1;
    i_map_waddr = a;
    i_map_wdata = d;
    tick();
    i_map_we    = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int start, input int exp_lat);
    int n;
    n = start;
    while (!o_color_valid && n < 12) begin
      tick();
      n++;
    end
    check({name, " latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic run_req(input string name, input logic [8:0] x, input logic [8:0] y,
                         input logic [8:0] sx, input logic [9:0] exp_addr);
    i_x         = x;
    i_y         = y;
    i_scroll_x  = sx;
    i_scroll_y  = 9'd0;
    i_pix_valid = 1'b1;
    tick();
    i_pix_valid = 1'b0;
    wait_valid(name, 1, 4);
    check({name, " addr"}, 32'(o_rom_address), 32'(exp_addr));
    check({name, " color"}, 32'(o_color), 32'(rom_f(exp_addr)));
    tick();
    check({name, " pulse"}, 32'(o_color_valid), 32'd0);
    check({name, " hold"}, 32'(o_color), 32'(rom_f(exp_addr)));
    check({name, " idle"}, 32'(o_busy), 32'd0);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  initial begin
    int vcount;
    i_rst       = 1'b1;
    i_pix_valid = 1'b0;
    i_x         = '0;
    i_y         = '0;
    i_scroll_x  = '0;
    i_scroll_y  = '0;
    i_map_we    = 1'b0;
    i_map_waddr = '0;
    i_map_wdata = '0;

    vecs[0] = '{9'd5,   9'd9,   10'd165};
    vecs[1] = '{9'd0,   9'd0,   10'd48};
    vecs[2] = '{9'd511, 9'd511, 10'd1023};
    vecs[3] = '{9'd10,  9'd6,   10'd730};
    vecs[4] = '{9'd6,   9'd11,  10'd174};
    vecs[5] = '{9'd4,   9'd0,   10'd192};

    // Map is loaded while reset is held; a strobe during reset must be ignored.
    tick();
    map_write(14'd257, 6'd10);
    map_write(14'd0, 6'd3);
    map_write(14'd127, 6'd7);
    map_write(14'd16383, 6'd63);
    map_write(14'd130, 6'd45);
    map_write(14'd1, 6'd12);
    i_pix_valid = 1'b1;
    tick();
    i_pix_valid = 1'b0;
    i_rst       = 1'b0;
    tick();
    check("reset busy", 32'(o_busy), 32'd0);
    check("reset valid", 32'(o_color_valid), 32'd0);
    check("reset color", 32'(o_color), 32'd0);
    check("reset addr", 32'(o_rom_address), 32'd0);
    check("reset drops", 32'(o_drop_count), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, 9'd0, vecs[i].addr);
    end
    check("back-to-back drops", 32'(o_drop_count), 32'd0);

`ifdef TILE_LAYER_SCROLL_EN
    run_req("scroll wrap", 9'd511, 9'd0, 9'd3, 10'd50);
`else
    run_req("scroll ignored", 9'd511, 9'd0, 9'd3, 10'd115);
`endif

    // Strobes on three consecutive cycles: first accepted, two dropped.
    do_reset();
    i_x         = 9'd5;
    i_y         = 9'd9;
    i_scroll_x  = 9'd0;
    i_pix_valid = 1'b1;
    tick();
    tick();
    tick();
    i_pix_valid = 1'b0;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_color_valid) vcount++;
      tick();
    end
    check("drop valids", 32'(vcount), 32'd1);
    check("drop count", 32'(o_drop_count), 32'd2);

    // Reset while in ROM_WAIT abandons the request.
    i_pix_valid = 1'b1;
    tick();
    i_pix_valid = 1'b0;
    tick();
    tick();
    check("midop busy before", 32'(o_busy), 32'd1);
    do_reset();
    check("midop busy", 32'(o_busy), 32'd0);
    check("midop valid", 32'(o_color_valid), 32'd0);
    check("midop color", 32'(o_color), 32'd0);
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_color_valid) vcount++;
      tick();
    end
    check("midop no valid", 32'(vcount), 32'd0);
    run_req("map intact", 9'd5, 9'd9, 9'd0, 10'd165);

    // Write to map[257] in the same cycle the FSM reads it.
    i_x         = 9'd5;
    i_y         = 9'd9;
    i_pix_valid = 1'b1;
    tick();
    i_pix_valid = 1'b0;
    i_map_we    = 1'b1;
    i_map_waddr = 14'd257;
    i_map_wdata = 6'd20;
    tick();
    i_map_we    = 1'b0;
    wait_valid("collision", 2, 4);
    check("collision addr", 32'(o_rom_address), 32'd165);
    tick();
    run_req("post collision", 9'd5, 9'd9, 9'd0, 10'd325);

    // Continuous strobing overflows the drop counter.
    i_pix_valid = 1'b1;
    repeat (400) tick();
    i_pix_valid = 1'b0;
    check("drop saturate", 32'(o_drop_count), 32'd255);
    repeat (6) tick();
    do_reset();
    check("drop cleared", 32'(o_drop_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
